// File: rtl/audio_pkg.sv
// Shared definitions for the audio playback/record datapath.
// Holds SRAM geometry, sample width, player FSM encoding and SRAM idle levels.
package audio_pkg;

    localparam int ADDR_W   = 18;
    localparam int SAMPLE_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_HOLD    = 3'd4,
        ST_DONE    = 3'd5
    } player_state_t;

    // Read-only port: write strobe parked high, both byte lanes always enabled.
    localparam logic SRAM_CE_N_IDLE = 1'b1;
    localparam logic SRAM_OE_N_IDLE = 1'b1;
    localparam logic SRAM_WE_N      = 1'b1;
    localparam logic SRAM_UB_N      = 1'b0;
    localparam logic SRAM_LB_N      = 1'b0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset and flush; empty/full are registered.
// Shared by the playback and record paths.
module sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          bclk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;
    logic [AW:0]   count_nxt;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (do_push && !do_pop)
            count_nxt = count + 1'b1;
        else if (do_pop && !do_push)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge bclk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge bclk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/sram_player.sv
// Playback fetch stage: sequential SRAM reads into a prefetch FIFO, one sample
// handed to the DAC serializer per sample_req, with end-of-recording and loop.
module sram_player
    import audio_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int READ_WAIT  = 1,
    parameter int ADDR_W     = audio_pkg::ADDR_W
) (
    input  logic                bclk,
    input  logic                rst,
    input  logic                play,
    input  logic                loop,
    input  logic [ADDR_W-1:0]   end_addr,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_we_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n,
    input  logic [SAMPLE_W-1:0] sram_dq,
    input  logic                sample_req,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    output logic                done,
    output logic                underrun
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int WC_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    player_state_t       st;
    logic                play_q, start;
    logic [ADDR_W-1:0]   cnt, end_q, cnt_nxt;
    logic [WC_W-1:0]     wcnt;
    logic                at_end, end_hit, full_after;
    logic                push, pop;
    logic [SAMPLE_W-1:0] head;
    logic [CW-1:0]       count;
    logic                empty, full;

    assign sram_we_n = SRAM_WE_N;
    assign sram_ub_n = SRAM_UB_N;
    assign sram_lb_n = SRAM_LB_N;

    assign start = play & ~play_q;
    assign push  = (st == ST_CAPTURE);
    assign pop   = sample_req & ~empty;

    assign sample       = empty ? '0 : head;
    assign sample_valid = ~empty;

    // Counter advance taken at CAPTURE; a non-loop end parks the counter.
    assign end_hit    = (cnt == end_q) && !loop;
    assign cnt_nxt    = (cnt == end_q) ? (loop ? '0 : cnt) : cnt + 1'b1;
    assign full_after = (count == CW'(FIFO_DEPTH - 1)) && !pop;

    sync_fifo #(.W(SAMPLE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .bclk  (bclk),
        .rst   (rst),
        .flush (~play),
        .push  (push),
        .pop   (pop),
        .wdata (sram_dq),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge bclk) begin
        if (rst) begin
            st        <= ST_IDLE;
            play_q    <= 1'b0;
            cnt       <= '0;
            end_q     <= '0;
            wcnt      <= '0;
            at_end    <= 1'b0;
            sram_addr <= '0;
            sram_ce_n <= SRAM_CE_N_IDLE;
            sram_oe_n <= SRAM_OE_N_IDLE;
            done      <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            play_q <= play;
            if (sample_req && empty)
                underrun <= 1'b1;

            if (!play) begin
                st        <= ST_IDLE;
                cnt       <= '0;
                at_end    <= 1'b0;
                sram_addr <= '0;
                sram_ce_n <= SRAM_CE_N_IDLE;
                sram_oe_n <= SRAM_OE_N_IDLE;
                done      <= 1'b0;
            end else begin
                case (st)
                    ST_IDLE: if (start) begin
                        end_q     <= end_addr;
                        underrun  <= 1'b0;
                        cnt       <= '0;
                        at_end    <= 1'b0;
                        sram_addr <= '0;
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        st        <= ST_ISSUE;
                    end
                    ST_ISSUE: begin
                        wcnt <= '0;
                        st   <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (wcnt == WC_W'(READ_WAIT - 1))
                            st <= ST_CAPTURE;
                        else
                            wcnt <= wcnt + 1'b1;
                    end
                    ST_CAPTURE: begin
                        cnt    <= cnt_nxt;
                        at_end <= end_hit;
                        if (end_hit || full_after) begin
                            sram_ce_n <= SRAM_CE_N_IDLE;
                            sram_oe_n <= SRAM_OE_N_IDLE;
                            st        <= ST_HOLD;
                        end else begin
                            // Back-to-back read: chip stays selected, address steps.
                            sram_addr <= cnt_nxt;
                            st        <= ST_ISSUE;
                        end
                    end
                    ST_HOLD: begin
                        if (at_end) begin
                            if (empty) begin
                                done <= 1'b1;
                                st   <= ST_DONE;
                            end
                        end else if (!full) begin
                            sram_addr <= cnt;
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            st        <= ST_ISSUE;
                        end
                    end
                    ST_DONE: st <= ST_DONE;
                    default: st <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sram_player.sv
// Directed bench for sram_player: SRAM model returns 0x100 + address.
// Covers playback, loop, underrun, stop mid-read, refill-on-demand and reset.
module tb_sram_player;

    logic        bclk = 1'b0;
    logic        rst, play, loop, sample_req;
    logic [17:0] end_addr, sram_addr;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;
    logic [15:0] sram_dq, sample;
    logic        sample_valid, done, underrun;

    int checks = 0;
    int fails  = 0;
    int lows;
    int ngot;
    logic [15:0] got [8];
    logic [15:0] loop_exp [7];
    logic        pf_seen = 1'b0;
    int          max_cnt = 0;

    always #5 bclk = ~bclk;

    assign sram_dq = (!sram_ce_n && !sram_oe_n) ? 16'h0100 + sram_addr[15:0] : 16'hDEAD;

    sram_player dut (
        .bclk(bclk), .rst(rst), .play(play), .loop(loop), .end_addr(end_addr),
        .sram_addr(sram_addr), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n),
        .sram_dq(sram_dq), .sample_req(sample_req), .sample(sample),
        .sample_valid(sample_valid), .done(done), .underrun(underrun)
    );

    always @(negedge bclk) begin
        if (!rst && dut.u_fifo.push && dut.u_fifo.full) pf_seen = 1'b1;
        if (int'(dut.u_fifo.count) > max_cnt) max_cnt = int'(dut.u_fifo.count);
    end

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " addr"}, 32'(sram_addr), 32'h0);
        chk({tag, " ce_n"}, 32'(sram_ce_n), 32'h1);
        chk({tag, " oe_n"}, 32'(sram_oe_n), 32'h1);
        chk({tag, " sample"}, 32'(sample), 32'h0);
        chk({tag, " valid"}, 32'(sample_valid), 32'h0);
        chk({tag, " done"}, 32'(done), 32'h0);
        chk({tag, " underrun"}, 32'(underrun), 32'h0);
    endtask

    task automatic pop_one();
        sample_req = 1'b1;
        tick();
        sample_req = 1'b0;
    endtask

    initial begin
        loop_exp = '{16'h100, 16'h101, 16'h102, 16'h100, 16'h101, 16'h102, 16'h100};
        rst = 1'b1; play = 1'b0; loop = 1'b0; sample_req = 1'b0; end_addr = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk_reset_vals("reset");
        chk("we_n", 32'(sram_we_n), 32'h1);
        chk("ub_lb", 32'({sram_ub_n, sram_lb_n}), 32'h0);

        // Single pass, end_addr=3
        end_addr = 18'd3; play = 1'b1;
        tick();
        chk("issue oe_n", 32'(sram_oe_n), 32'h0);
        chk("issue ce_n", 32'(sram_ce_n), 32'h0);
        chk("issue addr", 32'(sram_addr), 32'h0);
        tick(); tick();
        chk("pre-capture valid", 32'(sample_valid), 32'h0);
        tick();
        chk("first valid", 32'(sample_valid), 32'h1);
        chk("first sample", 32'(sample), 32'h100);
        repeat (15) tick();
        chk("full hold oe_n", 32'(sram_oe_n), 32'h1);
        chk("not done yet", 32'(done), 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk("pass sample", 32'(sample), 32'h100 + 32'(i));
            pop_one();
            tick();
        end
        tick();
        chk("pass done", 32'(done), 32'h1);
        chk("pass oe_n", 32'(sram_oe_n), 32'h1);
        chk("pass empty valid", 32'(sample_valid), 32'h0);
        chk("pass empty sample", 32'(sample), 32'h0);
        chk("pass underrun", 32'(underrun), 32'h0);
        play = 1'b0;
        tick();
        chk("done cleared", 32'(done), 32'h0);

        // Loop playback, end_addr=2
        loop = 1'b1; end_addr = 18'd2; play = 1'b1;
        tick();
        repeat (15) tick();
        for (int i = 0; i < 7; i++) begin
            chk("loop sample", 32'(sample), 32'(loop_exp[i]));
            chk("loop no done", 32'(done), 32'h0);
            pop_one();
            repeat (3) tick();
        end
        play = 1'b0; loop = 1'b0;
        tick();

        // Request every cycle from start: underrun, no dup/skip
        end_addr = 18'd5; play = 1'b1; sample_req = 1'b1;
        ngot = 0;
        max_cnt = 0;
        tick();
        repeat (40) begin
            if (sample_valid && ngot < 8) begin
                got[ngot] = sample;
                ngot++;
            end
            tick();
        end
        chk("stream count", 32'(ngot), 32'd6);
        for (int i = 0; i < 6; i++)
            chk("stream sample", 32'(got[i]), 32'h100 + 32'(i));
        chk("stream underrun", 32'(underrun), 32'h1);
        chk("stream done", 32'(done), 32'h1);
        chk("fifo bound", 32'(max_cnt <= 4), 32'h1);
        sample_req = 1'b0; play = 1'b0;
        tick();
        chk("underrun retained", 32'(underrun), 32'h1);
        chk("stop done clr", 32'(done), 32'h0);

        // Stop during WAIT of the second read, then restart
        end_addr = 18'd7; play = 1'b1;
        tick();
        chk("start clr underrun", 32'(underrun), 32'h0);
        tick(); tick(); tick();
        tick();
        chk("wait oe_n", 32'(sram_oe_n), 32'h0);
        chk("wait addr", 32'(sram_addr), 32'h1);
        play = 1'b0;
        tick();
        chk("stop valid", 32'(sample_valid), 32'h0);
        chk("stop addr", 32'(sram_addr), 32'h0);
        chk("stop oe_n", 32'(sram_oe_n), 32'h1);
        play = 1'b1;
        tick();
        repeat (3) tick();
        chk("restart valid", 32'(sample_valid), 32'h1);
        chk("restart sample", 32'(sample), 32'h100);
        play = 1'b0;
        tick();

        // Idle consumer: exactly FIFO_DEPTH reads, then one per request
        end_addr = 18'd100; play = 1'b1;
        tick();
        lows = 0;
        repeat (100) begin
            if (!sram_oe_n) lows++;
            tick();
        end
        chk("prefetch oe cycles", 32'(lows), 32'd12);
        chk("prefetch head", 32'(sample), 32'h100);
        pop_one();
        lows = 0;
        repeat (20) begin
            if (!sram_oe_n) lows++;
            tick();
        end
        chk("refill oe cycles", 32'(lows), 32'd3);
        chk("refill head", 32'(sample), 32'h101);
        play = 1'b0;
        tick();

        // Reset mid-playback with underrun set
        end_addr = 18'd7; play = 1'b1; sample_req = 1'b1;
        tick(); tick();
        sample_req = 1'b0;
        tick(); tick();
        chk("pre-rst underrun", 32'(underrun), 32'h1);
        chk("pre-rst valid", 32'(sample_valid), 32'h1);
        tick();
        rst = 1'b1;
        tick();
        chk_reset_vals("midrst");
        rst = 1'b0; play = 1'b0;
        tick();

        chk("no push when full", 32'(pf_seen), 32'h0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/sram_player.md
# sram_player

Playback fetch stage for the audio path: reads 16-bit samples sequentially from the external 256K×16 SRAM and holds them in a small prefetch FIFO. It hands one sample per request to the downstream DAC serializer, which pulses `sample_req` once per left-channel frame. It owns SRAM read sequencing, end-of-recording detection and loop playback, so the serializer only shifts bits.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: prefetch entries; power of two, ≥2.
- `READ_WAIT`, 1: cycles `sram_addr`/`sram_oe_n` are held before `sram_dq` is sampled; ≥1.
- `ADDR_W`, 18: SRAM address width.

Ports:
- `bclk` in 1: codec bit clock; sole clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `play` in 1: level; 1 = fetch/playback active, 0 = stop and flush.
- `loop` in 1: 1 = wrap to address 0 after `end_addr`.
- `end_addr` in ADDR_W: last valid sample address, inclusive; sampled on `play` rising edge.
- `sram_addr` out ADDR_W: SRAM address.
- `sram_ce_n`, `sram_oe_n` out 1: active-low chip enable / output enable.
- `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1: constant 1, 0, 0.
- `sram_dq` in 16: SRAM read data.
- `sample_req` in 1: one-cycle pulse from serializer; consumes FIFO head.
- `sample` out 16: FIFO head; 0 when FIFO empty.
- `sample_valid` out 1: FIFO non-empty.
- `done` out 1: playback finished (non-loop).
- `underrun` out 1: sticky; `sample_req` arrived while FIFO empty.

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE, HOLD, DONE.
- IDLE: `sram_ce_n`=`sram_oe_n`=1, address counter 0. `play` 0→1 latches `end_addr`, clears `underrun`, → ISSUE.
- ISSUE (1 cycle): drive `sram_addr`=counter, `ce_n`=`oe_n`=0 → WAIT.
- WAIT: hold for `READ_WAIT`−1 further cycles (0 if READ_WAIT=1) → CAPTURE.
- CAPTURE (1 cycle): register `sram_dq`, push into FIFO; counter update: if counter==end_addr then (loop ? 0 : hold); next state HOLD if FIFO would be full or non-loop end reached, else ISSUE.
- HOLD: `ce_n`=`oe_n`=1; → ISSUE when count<FIFO_DEPTH and end not reached; → DONE when end reached, non-loop, FIFO empty.
- DONE: `done`=1, outputs idle; stays until `play`=0.
- Reads are only issued when a free FIFO slot exists, so push into a full FIFO is impossible; verifier checks this as an assertion.
- `sample_req` with FIFO non-empty: pop; `sample` shows next entry (or 0) the following cycle. With FIFO empty: no pop, `underrun`←1.
- Same-cycle push and pop: count unchanged, both take effect.
- `play` 1→0 in any state: next cycle IDLE, FIFO flushed, counter 0, in-flight read discarded; `done` cleared; `underrun` retained until next start.
- `end_addr`=0: single sample played (or repeated with `loop`).

## Timing
- Reset values: `sram_addr`=0, `sram_ce_n`=`sram_oe_n`=1, `sample`=0, `sample_valid`=0, `done`=0, `underrun`=0, FSM IDLE, FIFO empty.
- Read cycle length READ_WAIT+2 cycles (ISSUE, WAIT, CAPTURE). With READ_WAIT=1: `play` rise at edge N → ISSUE at N+1, CAPTURE N+2, `sample_valid`=1 after edge N+3.
- Fill rate ≫ consumption (1 sample per 32 `bclk` frame); FIFO full within FIFO_DEPTH×(READ_WAIT+2)+1 cycles of start.
- All outputs registered; no combinational path from `sample_req` to `sram_*`.

## Structure
- Shared package `audio_pkg`: `ADDR_W`, `SAMPLE_W`=16, `player_state_t` enum, SRAM control idle constants.
- Sub-module `sync_fifo` (parameterised width/depth, push/pop/count/empty/full, synchronous reset and flush); reused later by the recorder path.

## Test plan
- Reset then `play`=1, `end_addr`=3, SRAM model returns addr+0x100 → samples 0x100..0x103 in order on four `sample_req` pulses, then `done`=1, `sram_oe_n`=1.
- `loop`=1, `end_addr`=2, 7 requests → 0x100,0x101,0x102,0x100,0x101,0x102,0x100; `done` never 1.
- `sample_req` pulsed every cycle from start → `underrun`=1, no duplicate or skipped sample, FIFO count never exceeds FIFO_DEPTH.
- `play` dropped during WAIT → next cycle IDLE, `sample_valid`=0, `sram_addr`=0; re-`play` restarts at 0x100.
- No `sample_req` for 100 cycles → exactly FIFO_DEPTH reads issued, then HOLD; one request → exactly one further read.
- `rst` asserted mid-playback → all outputs at reset values next cycle, `underrun` cleared.
